// File: rtl/fp17_to_fp16_pkg.sv
// Shared constants and types for the fp17->fp16 converter channel-A path.
package fp17_to_fp16_pkg;

  localparam int unsigned FP17_W      = 17;
  localparam int unsigned CHN_A_DEPTH = 2;

  // Occupancy of the 2-entry channel-A skid buffer: 0, 1 or 2.
  typedef logic [1:0] chn_a_count_t;

endpackage : fp17_to_fp16_pkg

// File: rtl/fp17_to_fp16_chn_a_skid_buf.sv
// Two-entry FIFO storage for the channel-A skid: data registers, 1-bit
// wrapping read/write pointers and an occupancy count. The caller guarantees
// no push when full and no pop when empty.
module fp17_to_fp16_chn_a_skid_buf
  import fp17_to_fp16_pkg::*;
#(
  parameter int unsigned WIDTH = FP17_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output chn_a_count_t     count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Write the incoming operand at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Advance pointers and track occupancy; simultaneous push/pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule : fp17_to_fp16_chn_a_skid_buf

// File: rtl/fp17_to_fp16_chn_a_rsci_skid.sv
// Channel-A input skid for the fp17->fp16 core: upstream valid/ready handshake
// into a 2-entry FIFO, presented to the core as bawt/d_mxwt.
// Optional macro FP17_TO_FP16_CHN_A_BYPASS_EN: when the FIFO is empty the
// upstream operand is forwarded combinationally (0-cycle latency).
module fp17_to_fp16_chn_a_rsci_skid
  import fp17_to_fp16_pkg::*;
#(
  parameter int unsigned WIDTH = FP17_W,
  parameter int unsigned DEPTH = CHN_A_DEPTH
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic [WIDTH-1:0] chn_a_rsc_z,
  input  logic             chn_a_rsc_vz,
  output logic             chn_a_rsc_lz,
  input  logic             chn_a_rsci_oswt,
  input  logic             core_wen,
  input  logic             core_wten,
  output logic             chn_a_rsci_bawt,
  output logic             chn_a_rsci_wen_comp,
  output logic [WIDTH-1:0] chn_a_rsci_d_mxwt
);

  chn_a_count_t     count;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;
  logic             buf_push;
  logic             buf_pop;

  // Ready comes from registered occupancy only, so it never depends on vz/oswt.
  assign chn_a_rsc_lz = (count != chn_a_count_t'(DEPTH));

  assign push = chn_a_rsc_vz & chn_a_rsc_lz;
  assign pop  = chn_a_rsci_oswt & core_wen & chn_a_rsci_bawt & ~core_wten;

`ifdef FP17_TO_FP16_CHN_A_BYPASS_EN
  logic bypass;

  // Empty with valid input: hand the input straight to the core. If the core
  // takes it this cycle it must not also land in storage.
  always_comb begin
    bypass            = (count == '0) & chn_a_rsc_vz;
    chn_a_rsci_bawt   = (count != '0) | bypass;
    chn_a_rsci_d_mxwt = bypass ? chn_a_rsc_z : head;
    buf_push          = push & ~(bypass & pop);
    buf_pop           = pop & ~bypass;
  end
`else
  // Core sees only stored operands.
  always_comb begin
    chn_a_rsci_bawt   = (count != '0);
    chn_a_rsci_d_mxwt = head;
    buf_push          = push;
    buf_pop           = pop;
  end
`endif

  assign chn_a_rsci_wen_comp = ~chn_a_rsci_oswt | chn_a_rsci_bawt;

  fp17_to_fp16_chn_a_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk   (nvdla_core_clk),
    .rst_n (nvdla_core_rstn),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (chn_a_rsc_z),
    .head  (head),
    .count (count)
  );

endmodule : fp17_to_fp16_chn_a_rsci_skid

// File: tb/tb_fp17_to_fp16_chn_a_rsci_skid.sv
// Self-checking bench for fp17_to_fp16_chn_a_rsci_skid against a queue model.
module tb_fp17_to_fp16_chn_a_rsci_skid;

  logic        clk = 1'b0;
  logic        rstn;
  logic [16:0] z;
  logic        vz, oswt, wen, wten;
  logic        lz, bawt, wen_comp;
  logic [16:0] d_mxwt;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          q[$];

  fp17_to_fp16_chn_a_rsci_skid #(
    .WIDTH (17),
    .DEPTH (2)
  ) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .chn_a_rsc_z         (z),
    .chn_a_rsc_vz        (vz),
    .chn_a_rsc_lz        (lz),
    .chn_a_rsci_oswt     (oswt),
    .core_wen            (wen),
    .core_wten           (wten),
    .chn_a_rsci_bawt     (bawt),
    .chn_a_rsci_wen_comp (wen_comp),
    .chn_a_rsci_d_mxwt   (d_mxwt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the queue model,
  // then advance the model by what the handshake rules say happens at the edge.
  task automatic cyc(input logic v, input logic [16:0] d, input logic os,
                     input logic w, input logic wt);
    logic        lz_e, bawt_e, byp, push_e, pop_e;
    logic [16:0] d_e;
    @(negedge clk);
    vz = v; z = d; oswt = os; wen = w; wten = wt;
    lz_e = (q.size() < 2);
    byp  = 1'b0;
`ifdef FP17_TO_FP16_CHN_A_BYPASS_EN
    byp  = (q.size() == 0) && v;
`endif
    bawt_e = (q.size() > 0) || byp;
    d_e    = byp ? d : ((q.size() > 0) ? 17'(q[0]) : 17'd0);
    #1;
    chk("lz", {16'd0, lz}, {16'd0, lz_e});
    chk("bawt", {16'd0, bawt}, {16'd0, bawt_e});
    chk("wen_comp", {16'd0, wen_comp}, {16'd0, (!os || bawt_e)});
    if (bawt_e) chk("d_mxwt", d_mxwt, d_e);
    push_e = v && lz_e;
    pop_e  = os && w && bawt_e && !wt;
    if (pop_e && !byp) void'(q.pop_front());
    if (push_e && !(byp && pop_e)) q.push_back(int'(d));
    @(posedge clk);
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_lz", {16'd0, lz}, 17'd1);
    chk("rst_bawt", {16'd0, bawt}, 17'd0);
    chk("rst_d_mxwt", d_mxwt, 17'd0);
    chk("rst_wen_comp", {16'd0, wen_comp}, {16'd0, ~oswt});
    q.delete();
    #4 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; z = '0; vz = 1'b0; oswt = 1'b0; wen = 1'b0; wten = 1'b0;
    #1;
    chk("init_lz", {16'd0, lz}, 17'd1);
    chk("init_bawt", {16'd0, bawt}, 17'd0);
    chk("init_d_mxwt", d_mxwt, 17'd0);
    chk("init_wen_comp_idle", {16'd0, wen_comp}, 17'd1);
    oswt = 1'b1;
    #1;
    chk("init_wen_comp_req", {16'd0, wen_comp}, 17'd0);
    oswt = 1'b0;
    #10 rstn = 1'b1;

    // Fill from upstream with no core request: two accepts then backpressure.
    for (int i = 0; i < 3; i++) cyc(1'b1, 17'h1ABCD, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 17'h0, 1'b0, 1'b1, 1'b0);

    // Reset while full discards both entries.
    do_reset();
    cyc(1'b0, 17'h0, 1'b0, 1'b1, 1'b0);

    // Streaming: one operand per cycle, in order, ready stays high.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 17'(i), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 17'h0, 1'b1, 1'b1, 1'b0);

    // Full with same-cycle pop and valid input: no push, count drops to 1.
    cyc(1'b1, 17'h00AA1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 17'h00AA2, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 17'h00AA3, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 17'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 17'h0, 1'b1, 1'b1, 1'b0);

    // Stall with a full buffer: held output, nothing leaves, upstream retained.
    cyc(1'b1, 17'h10001, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 17'h10002, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 17'h10003, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 17'h0, 1'b1, 1'b1, 1'b0);

    // Core request with an empty buffer, then with valid input present.
    cyc(1'b0, 17'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 17'h0FFFF, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 17'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 17'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional mid-transfer resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      cyc(1'($urandom_range(0, 3) != 0), 17'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) != 0),
          1'($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fp17_to_fp16_chn_a_rsci_skid
